// File: rtl/mem_burst_axi_bridge.sv
// mem_burst_axi_bridge
// Responder side of the burst memory interface. Accepts one rd/wr burst request at a
// time and executes it as a chain of AXI4 INCR bursts of at most MAX_BURST beats.
// Write words are pulled from the initiator through a 2-entry FIFO so wvalid can stream
// at one beat per cycle. Read beats are re-registered before they reach the initiator.
module mem_burst_axi_bridge #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 32,
    parameter int MAX_BURST     = 128
) (
    input  logic                       mem_clk,
    input  logic                       rst_n,
    // burst request side
    input  logic                       rd_burst_req,
    input  logic                       wr_burst_req,
    input  logic [9:0]                 rd_burst_len,
    input  logic [9:0]                 wr_burst_len,
    input  logic [ADDR_BITS-1:0]       rd_burst_addr,
    input  logic [ADDR_BITS-1:0]       wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
    output logic                       rd_burst_data_valid,
    output logic                       wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0]   wr_burst_data,
    output logic                       rd_burst_finish,
    output logic                       wr_burst_finish,
    // AXI write address
    output logic [ADDR_BITS-1:0]       m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    // AXI write data
    output logic [MEM_DATA_BITS-1:0]   m_axi_wdata,
    output logic [MEM_DATA_BITS/8-1:0] m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    // AXI write response
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    // AXI read address
    output logic [ADDR_BITS-1:0]       m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    // AXI read data
    input  logic [MEM_DATA_BITS-1:0]   m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    // status
    output logic                       resp_error
);

    localparam int         STRB_BITS   = MEM_DATA_BITS / 8;
    localparam int         SIZE_LOG2   = $clog2(STRB_BITS);
    localparam logic [9:0] MAX_BURST_W = 10'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;          // next sub-burst start, word units
    logic [9:0]               remaining_q, remaining_d;
    logic [9:0]               sub_len_q, sub_len_d;    // beats in the current sub-burst
    logic [9:0]               req_cnt_q, req_cnt_d;    // write words requested so far
    logic [9:0]               beat_cnt_q, beat_cnt_d;  // write beats sent so far
    logic                     pending_q, pending_d;    // a word arrives this cycle
    logic [MEM_DATA_BITS-1:0] fifo_mem_q [2];
    logic [MEM_DATA_BITS-1:0] fifo_mem_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;
    logic [MEM_DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     resp_error_q, resp_error_d;

    logic [9:0]               sub_n;
    logic [7:0]               axlen;
    logic [ADDR_BITS-1:0]     byte_addr;
    logic                     push, pop, last_beat, data_req;
    logic [2:0]               fifo_claim;
    logic                     wr_fin, rd_fin;

    // Shared sub-burst sizing and the write-FIFO flow control terms.
    always_comb begin
        sub_n      = (remaining_q > MAX_BURST_W) ? MAX_BURST_W : remaining_q;
        axlen      = 8'(sub_n - 10'd1);
        byte_addr  = addr_q << SIZE_LOG2;
        push       = pending_q;
        pop        = (count_q != 2'd0) && m_axi_wready;
        last_beat  = (beat_cnt_q == sub_len_q - 10'd1);
        // Slots already spoken for after this cycle; counting the pop lets a new
        // request go out every cycle while the slave keeps wready high.
        fifo_claim = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
        data_req   = (state_q == WR_DATA) && (req_cnt_q != sub_len_q) && (fifo_claim < 3'd2);
        wr_fin     = (state_q == DONE) && op_wr_q;
        // A read finishes only once its last data word has been presented.
        rd_fin     = (state_q == DONE) && !op_wr_q && !rd_valid_q;
    end

    // Next-state logic and request/sub-burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        sub_len_d   = sub_len_q;
        req_cnt_d   = req_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_burst_req) begin
                    op_wr_d     = 1'b1;
                    addr_d      = wr_burst_addr;
                    remaining_d = wr_burst_len;
                    state_d     = (wr_burst_len == 10'd0) ? DONE : WR_ADDR;
                end else if (rd_burst_req) begin
                    op_wr_d     = 1'b0;
                    addr_d      = rd_burst_addr;
                    remaining_d = rd_burst_len;
                    state_d     = (rd_burst_len == 10'd0) ? DONE : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (m_axi_awready) begin
                    sub_len_d   = sub_n;
                    addr_d      = addr_q + ADDR_BITS'(sub_n);
                    remaining_d = remaining_q - sub_n;
                    req_cnt_d   = 10'd0;
                    beat_cnt_d  = 10'd0;
                    state_d     = WR_DATA;
                end
            end
            WR_DATA: begin
                if (data_req) begin
                    req_cnt_d = req_cnt_q + 10'd1;
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + 10'd1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = (remaining_q != 10'd0) ? WR_ADDR : DONE;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    addr_d      = addr_q + ADDR_BITS'(sub_n);
                    remaining_d = remaining_q - sub_n;
                    state_d     = RD_DATA;
                end
            end
            RD_DATA: begin
                // rlast closes the sub-burst regardless of how many beats were counted.
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_d = (remaining_q != 10'd0) ? RD_ADDR : DONE;
                end
            end
            DONE: begin
                if (wr_fin || rd_fin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write FIFO, read-data pipeline register and sticky error flag.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = wr_burst_data;
        end
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        pending_d    = data_req;
        rd_valid_d   = (state_q == RD_DATA) && m_axi_rvalid;
        rd_data_d    = rd_valid_d ? m_axi_rdata : rd_data_q;
        resp_error_d = resp_error_q
                     | ((state_q == WR_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00))
                     | ((state_q == RD_DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00));
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            remaining_q  <= '0;
            sub_len_q    <= '0;
            req_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            pending_q    <= 1'b0;
            fifo_mem_q   <= '{default: '0};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            sub_len_q    <= sub_len_d;
            req_cnt_q    <= req_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            pending_q    <= pending_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Address payloads are zeroed outside their address phase so idle outputs read 0.
    assign m_axi_awvalid = (state_q == WR_ADDR);
    assign m_axi_awaddr  = m_axi_awvalid ? byte_addr : '0;
    assign m_axi_awlen   = m_axi_awvalid ? axlen : 8'd0;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = 2'b01;

    assign m_axi_wvalid  = (count_q != 2'd0);
    assign m_axi_wdata   = fifo_mem_q[rd_ptr_q];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid && last_beat;
    assign m_axi_bready  = (state_q == WR_RESP);

    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? byte_addr : '0;
    assign m_axi_arlen   = m_axi_arvalid ? axlen : 8'd0;
    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (state_q == RD_DATA);

    assign wr_burst_data_req   = data_req;
    assign rd_burst_data       = rd_data_q;
    assign rd_burst_data_valid = rd_valid_q;
    assign wr_burst_finish     = wr_fin;
    assign rd_burst_finish     = rd_fin;
    assign resp_error          = resp_error_q;

endmodule

// File: tb/tb_mem_burst_axi_bridge.sv
// Directed bench for mem_burst_axi_bridge: a small AXI slave / initiator responder runs
// in the background and logs every handshake; the main sequence issues requests and
// compares the logs against hand-computed expectations.
module tb_mem_burst_axi_bridge;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          mem_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rd_burst_req, wr_burst_req;
    logic [9:0]    rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_data_valid, wr_burst_data_req;
    logic [DW-1:0] wr_burst_data;
    logic          rd_burst_finish, wr_burst_finish;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]    m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic          resp_error;

    always #5 mem_clk = ~mem_clk;

    mem_burst_axi_bridge #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .MAX_BURST(128)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .resp_error(resp_error)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wpat(input int i);
        return {32'hC0DE_0000, 32'(i * 3 + 1)};
    endfunction

    function automatic logic [63:0] rpat(input int i);
        return {32'h5EAD_0000, 32'(i * 5 + 2)};
    endfunction

    // handshake logs
    logic [AW-1:0] aw_addr_log[$], ar_addr_log[$];
    logic [7:0]    aw_len_log[$], ar_len_log[$];
    logic [DW-1:0] w_log[$], rd_log[$];
    int            wlast_pos[$];
    int cyc = 0;
    int first_w_cyc, last_w_cyc, b_cyc, last_dv_cyc, wr_fin_cyc, rd_fin_cyc, first_ar_cyc;
    int wr_fin_cnt, rd_fin_cnt, req_total, max_out, valid_seen, wr_seq;
    // slave model state and knobs
    int  b_pending, r_left, r_idx, slverr_idx;
    int  ar_pend[$];
    bit  data_req_prev, wready_rand, rvalid_rand;

    task automatic clear_logs();
        aw_addr_log.delete(); aw_len_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
        w_log.delete(); rd_log.delete(); wlast_pos.delete();
        first_w_cyc = -1; last_w_cyc = -1; b_cyc = -1; last_dv_cyc = -1;
        wr_fin_cyc = -1; rd_fin_cyc = -1; first_ar_cyc = -1;
        wr_fin_cnt = 0; rd_fin_cnt = 0; req_total = 0; max_out = 0; valid_seen = 0;
        wr_seq = 0; r_idx = 0;
    endtask

    // Background responder: drives slave/initiator inputs on negedge, logs handshakes 1ns later.
    initial begin
        m_axi_awready = 1'b0; m_axi_arready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        wr_burst_data = '0;
        forever begin
            @(negedge mem_clk);
            if (!rst_n) begin
                b_pending = 0; r_left = 0; ar_pend.delete(); data_req_prev = 1'b0;
                m_axi_awready = 1'b0; m_axi_arready = 1'b0; m_axi_wready = 1'b0;
                m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                wr_burst_data = '0;
            end else begin
                m_axi_awready = 1'b1;
                m_axi_arready = 1'b1;
                m_axi_wready  = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_bvalid  = (b_pending > 0);
                m_axi_bresp   = 2'b00;
                if (r_left == 0 && ar_pend.size() > 0) r_left = ar_pend.pop_front();
                if (r_left > 0) begin
                    m_axi_rvalid = rvalid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    m_axi_rdata  = rpat(r_idx);
                    m_axi_rlast  = (r_left == 1);
                    m_axi_rresp  = (r_idx == slverr_idx) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                    m_axi_rdata  = '1;
                end
                wr_burst_data = data_req_prev ? wpat(wr_seq) : 64'hBAD0_BAD0_BAD0_BAD0;
                if (data_req_prev) wr_seq++;
                #1;
                cyc++;
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_addr_log.push_back(m_axi_awaddr); aw_len_log.push_back(m_axi_awlen);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_addr_log.push_back(m_axi_araddr); ar_len_log.push_back(m_axi_arlen);
                    ar_pend.push_back(int'(m_axi_arlen) + 1);
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                end
                if (wr_burst_data_req) req_total++;
                if (m_axi_wvalid && m_axi_wready) begin
                    w_log.push_back(m_axi_wdata);
                    if (m_axi_wlast) begin
                        wlast_pos.push_back(w_log.size() - 1);
                        b_pending++;
                    end
                    if (first_w_cyc < 0) first_w_cyc = cyc;
                    last_w_cyc = cyc;
                end
                if (req_total - w_log.size() > max_out) max_out = req_total - w_log.size();
                if (m_axi_bvalid && m_axi_bready) begin b_pending--; b_cyc = cyc; end
                if (m_axi_rvalid && m_axi_rready) begin r_left--; r_idx++; end
                if (rd_burst_data_valid) begin rd_log.push_back(rd_burst_data); last_dv_cyc = cyc; end
                if (wr_burst_finish) begin wr_fin_cnt++; wr_fin_cyc = cyc; end
                if (rd_burst_finish) begin rd_fin_cnt++; rd_fin_cyc = cyc; end
                if (m_axi_awvalid || m_axi_arvalid || m_axi_wvalid) valid_seen++;
                data_req_prev = wr_burst_data_req;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                               m_axi_rready, wr_burst_data_req, rd_burst_data_valid,
                               wr_burst_finish, rd_burst_finish, resp_error, m_axi_wlast}, '0);
        check({tag, "_awaddr"}, m_axi_awaddr, '0);
        check({tag, "_araddr"}, m_axi_araddr, '0);
        check({tag, "_axlen"}, {m_axi_awlen, m_axi_arlen}, '0);
        check({tag, "_wdata"}, m_axi_wdata, '0);
        check({tag, "_rdata"}, rd_burst_data, '0);
    endtask

    // Waits (bounded) for the finish pulse of one op, then drops that request.
    task automatic wait_fin(input bit is_wr, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 5000) begin
            if (is_wr ? wr_burst_finish : rd_burst_finish) seen = 1'b1;
            else begin
                @(negedge mem_clk); #2; n++;
            end
        end
        check({tag, "_finish_seen"}, 64'(seen), 64'd1);
        if (is_wr) wr_burst_req = 1'b0; else rd_burst_req = 1'b0;
    endtask

    task automatic run_req(input bit is_wr, input logic [AW-1:0] addr, input logic [9:0] len,
                           input string tag, output int t0);
        @(negedge mem_clk);
        if (is_wr) begin wr_burst_addr = addr; wr_burst_len = len; wr_burst_req = 1'b1; end
        else       begin rd_burst_addr = addr; rd_burst_len = len; rd_burst_req = 1'b1; end
        #2 t0 = cyc;
        wait_fin(is_wr, tag);
        repeat (3) @(negedge mem_clk);
        #2;
    endtask

    function automatic int w_errs();
        int e = 0;
        foreach (w_log[i]) if (w_log[i] !== wpat(i)) e++;
        return e;
    endfunction

    function automatic int r_errs();
        int e = 0;
        foreach (rd_log[i]) if (rd_log[i] !== rpat(i)) e++;
        return e;
    endfunction

    initial begin
        int t0;
        int n;
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        rd_burst_len = '0;   wr_burst_len = '0;
        rd_burst_addr = '0;  wr_burst_addr = '0;
        wready_rand = 1'b0;  rvalid_rand = 1'b0; slverr_idx = -1;
        clear_logs();

        // reset state and constant fields
        repeat (3) @(negedge mem_clk);
        #2;
        check_outputs_zero("reset");
        check("const_axsize", {m_axi_awsize, m_axi_arsize}, {3'd3, 3'd3});
        check("const_axburst", {m_axi_awburst, m_axi_arburst}, 4'b0101);
        check("const_wstrb", m_axi_wstrb, 8'hFF);
        @(negedge mem_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge mem_clk);

        // 1: single 128-beat write, everything ready
        clear_logs();
        run_req(1'b1, 32'h0200_0000, 10'd128, "t1", t0);
        check("t1_aw_count", aw_addr_log.size(), 1);
        check("t1_awaddr", aw_addr_log[0], 32'h1000_0000);
        check("t1_awlen", aw_len_log[0], 8'd127);
        check("t1_wbeats", w_log.size(), 128);
        check("t1_wdata_errs", w_errs(), 0);
        check("t1_wlast_count", wlast_pos.size(), 1);
        check("t1_wlast_pos", wlast_pos[0], 127);
        check("t1_b2b_span", last_w_cyc - first_w_cyc, 127);
        check("t1_fin_after_b", wr_fin_cyc - b_cyc, 1);
        check("t1_fin_count", wr_fin_cnt, 1);
        check("t1_resp_error", resp_error, 1'b0);

        // 2: 300-word read split 128/128/44
        clear_logs();
        run_req(1'b0, 32'h0, 10'd300, "t2", t0);
        check("t2_ar_count", ar_addr_log.size(), 3);
        check("t2_araddr", {ar_addr_log[0], ar_addr_log[1], ar_addr_log[2]},
              {32'h0, 32'h400, 32'h800});
        check("t2_arlen", {ar_len_log[0], ar_len_log[1], ar_len_log[2]}, {8'd127, 8'd127, 8'd43});
        check("t2_rbeats", rd_log.size(), 300);
        check("t2_rdata_errs", r_errs(), 0);
        check("t2_fin_after_dv", rd_fin_cyc - last_dv_cyc, 1);
        check("t2_fin_count", rd_fin_cnt, 1);

        // 3: 200-word write with random wready
        clear_logs();
        wready_rand = 1'b1;
        run_req(1'b1, 32'h100, 10'd200, "t3", t0);
        wready_rand = 1'b0;
        check("t3_aw_count", aw_addr_log.size(), 2);
        check("t3_awaddr", {aw_addr_log[0], aw_addr_log[1]}, {32'h800, 32'hC00});
        check("t3_awlen", {aw_len_log[0], aw_len_log[1]}, {8'd127, 8'd71});
        check("t3_wbeats", w_log.size(), 200);
        check("t3_wdata_errs", w_errs(), 0);
        check("t3_wlast_pos", {32'(wlast_pos.size()), 32'(wlast_pos[0]), 32'(wlast_pos[1])},
              {32'd2, 32'd127, 32'd199});
        check("t3_outstanding_le2", 64'(max_out <= 2), 64'd1);
        check("t3_fin_count", wr_fin_cnt, 1);

        // 4: read with rvalid gaps and SLVERR on beat 5
        clear_logs();
        rvalid_rand = 1'b1; slverr_idx = 5;
        run_req(1'b0, 32'h40, 10'd20, "t4", t0);
        rvalid_rand = 1'b0; slverr_idx = -1;
        check("t4_ar", {ar_addr_log.size(), ar_addr_log[0], ar_len_log[0]},
              {32'd1, 32'h200, 8'd19});
        check("t4_rbeats", rd_log.size(), 20);
        check("t4_rdata_errs", r_errs(), 0);
        check("t4_resp_error", resp_error, 1'b1);
        check("t4_fin_count", rd_fin_cnt, 1);

        // 5: simultaneous wr/rd requests -> write first; then zero-length requests
        clear_logs();
        @(negedge mem_clk);
        wr_burst_addr = 32'h10; wr_burst_len = 10'd3; wr_burst_req = 1'b1;
        rd_burst_addr = 32'h20; rd_burst_len = 10'd4; rd_burst_req = 1'b1;
        #2;
        wait_fin(1'b1, "t5_wr");
        wait_fin(1'b0, "t5_rd");
        repeat (3) @(negedge mem_clk);
        #2;
        check("t5_aw", {aw_addr_log.size(), aw_addr_log[0], aw_len_log[0]}, {32'd1, 32'h80, 8'd2});
        check("t5_ar", {ar_addr_log.size(), ar_addr_log[0], ar_len_log[0]}, {32'd1, 32'h100, 8'd3});
        check("t5_write_first", 64'(first_ar_cyc > wr_fin_cyc), 64'd1);
        check("t5_beats", {w_log.size(), rd_log.size()}, {32'd3, 32'd4});
        check("t5_fin_counts", {wr_fin_cnt, rd_fin_cnt}, {32'd1, 32'd1});
        check("t5_resp_error_sticky", resp_error, 1'b1);

        clear_logs();
        run_req(1'b1, 32'h55, 10'd0, "t5_wr0", t0);
        check("t5_wr0_latency", wr_fin_cyc - t0, 1);
        check("t5_wr0_fin_count", wr_fin_cnt, 1);
        run_req(1'b0, 32'h66, 10'd0, "t5_rd0", t0);
        check("t5_rd0_latency", rd_fin_cyc - t0, 1);
        check("t5_len0_no_axi", valid_seen, 0);

        // 6: reset in the middle of WR_DATA, then a fresh write
        clear_logs();
        @(negedge mem_clk);
        wr_burst_addr = 32'h0; wr_burst_len = 10'd50; wr_burst_req = 1'b1;
        n = 0;
        while (w_log.size() < 5 && n < 500) begin @(negedge mem_clk); #2; n++; end
        check("t6_midburst_reached", 64'(w_log.size() >= 5), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        wr_burst_req = 1'b0;
        repeat (2) @(negedge mem_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge mem_clk);
        clear_logs();
        run_req(1'b1, 32'h8, 10'd4, "t6", t0);
        check("t6_aw", {aw_addr_log.size(), aw_addr_log[0], aw_len_log[0]}, {32'd1, 32'h40, 8'd3});
        check("t6_wbeats", w_log.size(), 4);
        check("t6_wdata_errs", w_errs(), 0);
        check("t6_fin_count", wr_fin_cnt, 1);
        check("t6_resp_error_cleared", resp_error, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
